// File: rtl/dag_sub_circ_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dag_sub_circ_pkg
//  Brief    : Shared constants and carry-lookahead helper for the DAG
//             post-decrement update unit.
//  Revision : 1.0 - initial release
// ============================================================================
package dag_sub_circ_pkg;

   localparam int DAG_AW   = 14;
   localparam int CLA_GRP  = 4;
   localparam int CLA_MAXG = 8;

   // Carry out of the lowest n positions of a generate/propagate chain.
   function automatic logic cla_carry(input logic [CLA_MAXG-1:0] g,
                                      input logic [CLA_MAXG-1:0] p,
                                      input logic                cin,
                                      input int                  n);
      logic c;
      c = cin;
      for (int j = 0; j < CLA_MAXG; j++) begin
         if (j < n) c = g[j] | (p[j] & c);
      end
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dag_sub15.sv
`default_nettype none
// ============================================================================
//  Module   : dag_sub15
//  Brief    : Combinational W-bit carry-lookahead subtractor, SUM = A + ~B + Cin.
//  Revision : 1.0 - initial release
// ============================================================================
module dag_sub15
   import dag_sub_circ_pkg::*;
#(
   parameter int W = DAG_AW + 1
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         neg_o
);

   localparam int NG = (W + CLA_GRP - 1) / CLA_GRP;

   logic [W-1:0]  w_bn;
   logic [W-1:0]  w_g;
   logic [W-1:0]  w_p;
   logic [W-1:0]  w_c;
   logic [NG-1:0] w_gg;
   logic [NG-1:0] w_gp;
   logic [NG-1:0] w_gc;

   assign w_bn = ~b_i;
   assign w_g  = a_i & w_bn;
   assign w_p  = a_i ^ w_bn;

   // Group generate/propagate, then group carries looked ahead from cin.
   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam int LO = gi * CLA_GRP;
      localparam int N  = ((W - LO) < CLA_GRP) ? (W - LO) : CLA_GRP;

      assign w_gg[gi] = cla_carry(CLA_MAXG'(w_g[LO +: N]),
                                  CLA_MAXG'(w_p[LO +: N]), 1'b0, N);
      assign w_gp[gi] = &w_p[LO +: N];
      assign w_gc[gi] = cla_carry(CLA_MAXG'(w_gg), CLA_MAXG'(w_gp), cin_i, gi);
   end

   for (genvar bi = 0; bi < W; bi++) begin : g_bit
      localparam int GI = bi / CLA_GRP;
      localparam int J  = bi % CLA_GRP;

      if (J == 0) begin : g_lead
         assign w_c[bi] = w_gc[GI];
      end else begin : g_inner
         assign w_c[bi] = cla_carry(CLA_MAXG'(w_g[GI*CLA_GRP +: J]),
                                    CLA_MAXG'(w_p[GI*CLA_GRP +: J]),
                                    w_gc[GI], J);
      end
   end

   assign sum_o = w_p ^ w_c;
   assign neg_o = sum_o[W-1];

endmodule
`default_nettype wire

// File: rtl/dag_sub_circ.sv
`default_nettype none
// ============================================================================
//  Module   : dag_sub_circ
//  Brief    : Two-stage post-decrement index update I - M with optional
//             circular wrap against base B and length L (L = 0 is linear).
//  Revision : 1.0 - initial release
// ============================================================================
module dag_sub_circ
   import dag_sub_circ_pkg::*;
#(
   parameter int AW = DAG_AW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IN_VLD,
   output logic          IN_RDY,
   input  logic [AW-1:0] I_IN,
   input  logic [AW-1:0] M_IN,
   input  logic [AW-1:0] B_IN,
   input  logic [AW-1:0] L_IN,
   output logic          OUT_VLD,
   input  logic          OUT_RDY,
   output logic [AW-1:0] ADDR_OUT,
   output logic          WRAP_OUT,
   output logic          BOR_OUT
);

   logic          s1_vld_q,  s1_vld_d;
   logic [AW:0]   s1_d_q,    s1_d_d;
   logic [AW-1:0] s1_b_q,    s1_b_d;
   logic [AW-1:0] s1_l_q,    s1_l_d;
   logic          s1_bor_q,  s1_bor_d;

   logic          s2_vld_q,  s2_vld_d;
   logic [AW-1:0] s2_addr_q, s2_addr_d;
   logic          s2_wrap_q, s2_wrap_d;
   logic          s2_bor_q,  s2_bor_d;

   logic          w_s1_adv;
   logic          w_s2_adv;
   logic [AW:0]   w_diff;
   logic          w_diff_neg;
   logic [AW:0]   w_wsum;
   logic          w_wsum_neg;
   logic          w_below_base;
   logic          w_do_wrap;
   logic          w_unused_wrap;

   assign w_s2_adv = !s2_vld_q | OUT_RDY;
   assign w_s1_adv = !s1_vld_q | w_s2_adv;
   assign IN_RDY   = w_s1_adv;

   // Stage 1: {0,I} + {1,~M} + 1
   dag_sub15 #(.W(AW + 1)) u_sub_s1 (
      .a_i   ({1'b0, I_IN}),
      .b_i   ({1'b0, M_IN}),
      .cin_i (1'b1),
      .sum_o (w_diff),
      .neg_o (w_diff_neg)
   );

   // Stage 2: D + {0,L} using the same subtractor with inverted operand.
   dag_sub15 #(.W(AW + 1)) u_sub_wrap (
      .a_i   (s1_d_q),
      .b_i   (~{1'b0, s1_l_q}),
      .cin_i (1'b0),
      .sum_o (w_wsum),
      .neg_o (w_wsum_neg)
   );

   assign w_unused_wrap = ^{w_wsum_neg, w_wsum[AW]};
   assign w_below_base  = $signed(s1_d_q) < $signed({1'b0, s1_b_q});
   assign w_do_wrap     = (s1_l_q != '0) && w_below_base;

   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_d_d    = s1_d_q;
      s1_b_d    = s1_b_q;
      s1_l_d    = s1_l_q;
      s1_bor_d  = s1_bor_q;
      s2_vld_d  = s2_vld_q;
      s2_addr_d = s2_addr_q;
      s2_wrap_d = s2_wrap_q;
      s2_bor_d  = s2_bor_q;

      if (w_s1_adv) begin
         s1_vld_d = IN_VLD;
         if (IN_VLD) begin
            s1_d_d   = w_diff;
            s1_b_d   = B_IN;
            s1_l_d   = L_IN;
            s1_bor_d = w_diff_neg;
         end
      end

      if (w_s2_adv) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_addr_d = w_do_wrap ? w_wsum[AW-1:0] : s1_d_q[AW-1:0];
            s2_wrap_d = w_do_wrap;
            s2_bor_d  = s1_bor_q;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_vld_q  <= 1'b0;
         s1_d_q    <= '0;
         s1_b_q    <= '0;
         s1_l_q    <= '0;
         s1_bor_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         s2_addr_q <= '0;
         s2_wrap_q <= 1'b0;
         s2_bor_q  <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_d_q    <= s1_d_d;
         s1_b_q    <= s1_b_d;
         s1_l_q    <= s1_l_d;
         s1_bor_q  <= s1_bor_d;
         s2_vld_q  <= s2_vld_d;
         s2_addr_q <= s2_addr_d;
         s2_wrap_q <= s2_wrap_d;
         s2_bor_q  <= s2_bor_d;
      end
   end

   assign OUT_VLD  = s2_vld_q;
   assign ADDR_OUT = s2_addr_q;
   assign WRAP_OUT = s2_wrap_q;
   assign BOR_OUT  = s2_bor_q;

endmodule
`default_nettype wire

// File: tb/tb_dag_sub_circ.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dag_sub_circ
//  Brief    : Table-driven, scoreboard-checked bench for dag_sub_circ.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dag_sub_circ;

   localparam int AW = 14;

   typedef struct {
      logic [AW-1:0] i;
      logic [AW-1:0] m;
      logic [AW-1:0] b;
      logic [AW-1:0] l;
      logic [AW-1:0] addr;
      logic          wrap;
      logic          bor;
   } vec_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          IN_VLD = 1'b0;
   logic          IN_RDY;
   logic [AW-1:0] I_IN = '0;
   logic [AW-1:0] M_IN = '0;
   logic [AW-1:0] B_IN = '0;
   logic [AW-1:0] L_IN = '0;
   logic          OUT_VLD;
   logic          OUT_RDY = 1'b1;
   logic [AW-1:0] ADDR_OUT;
   logic          WRAP_OUT;
   logic          BOR_OUT;

   dag_sub_circ #(.AW(AW)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .IN_VLD   (IN_VLD),
      .IN_RDY   (IN_RDY),
      .I_IN     (I_IN),
      .M_IN     (M_IN),
      .B_IN     (B_IN),
      .L_IN     (L_IN),
      .OUT_VLD  (OUT_VLD),
      .OUT_RDY  (OUT_RDY),
      .ADDR_OUT (ADDR_OUT),
      .WRAP_OUT (WRAP_OUT),
      .BOR_OUT  (BOR_OUT)
   );

   always #5 CLK = ~CLK;

   int    checks   = 0;
   int    failures = 0;
   vec_t  sb[$];
   int    stepn    = 0;
   int    xfer_cnt = 0;
   int    acc_cnt  = 0;
   int    first_xfer = -1;
   int    last_xfer  = -1;
   logic  last_acc   = 1'b0;
   logic  stall_prev = 1'b0;
   logic [31:0] held = '0;
   vec_t  idle_v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [AW-1:0] i, m, b, l, addr,
                               input logic wrap, bor);
      vec_t v;
      v.i = i; v.m = m; v.b = b; v.l = l;
      v.addr = addr; v.wrap = wrap; v.bor = bor;
      return v;
   endfunction

   // Called just after a falling edge; drives, samples, then advances one cycle.
   task automatic step(input logic vld, input vec_t v, input logic ordy);
      vec_t e;
      IN_VLD = vld; I_IN = v.i; M_IN = v.m; B_IN = v.b; L_IN = v.l;
      OUT_RDY = ordy;
      #1;
      if (stall_prev)
         chk("stall_hold", {17'd0, OUT_VLD, WRAP_OUT, BOR_OUT, ADDR_OUT}, held);
      stall_prev = OUT_VLD & ~OUT_RDY;
      held       = {17'd0, OUT_VLD, WRAP_OUT, BOR_OUT, ADDR_OUT};
      if (OUT_VLD && OUT_RDY) begin
         xfer_cnt++;
         if (first_xfer < 0) first_xfer = stepn;
         last_xfer = stepn;
         if (sb.size() == 0) begin
            chk("unexpected_out", 32'(ADDR_OUT), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("addr", 32'(ADDR_OUT), 32'(e.addr));
            chk("wrap", 32'(WRAP_OUT), 32'(e.wrap));
            chk("bor",  32'(BOR_OUT),  32'(e.bor));
         end
      end
      last_acc = IN_VLD & IN_RDY;
      if (last_acc) begin
         sb.push_back(v);
         acc_cnt++;
      end
      stepn++;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb.size() != 0; k++) step(1'b0, idle_v, 1'b1);
      chk("drain_empty", 32'(sb.size()), 32'd0);
      step(1'b0, idle_v, 1'b1);
      step(1'b0, idle_v, 1'b1);
   endtask

   vec_t tbl[11];
   vec_t bp[3];

   initial begin
      idle_v = mk('0, '0, '0, '0, '0, 1'b0, 1'b0);
      tbl[0]  = mk(14'h0010, 14'h0003, 14'h0000, 14'h0000, 14'h000D, 1'b0, 1'b0);
      tbl[1]  = mk(14'h0002, 14'h0005, 14'h0000, 14'h0000, 14'h3FFD, 1'b0, 1'b1);
      tbl[2]  = mk(14'h0102, 14'h0004, 14'h0100, 14'h0010, 14'h010E, 1'b1, 1'b0);
      tbl[3]  = mk(14'h0104, 14'h0004, 14'h0100, 14'h0010, 14'h0100, 1'b0, 1'b0);
      tbl[4]  = mk(14'h0002, 14'h0003, 14'h0000, 14'h0008, 14'h0007, 1'b1, 1'b1);
      tbl[5]  = mk(14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1'b0, 1'b0);
      tbl[6]  = mk(14'h3FFF, 14'h3FFF, 14'h0000, 14'h0000, 14'h0000, 1'b0, 1'b0);
      tbl[7]  = mk(14'h3FF0, 14'h0000, 14'h3FF0, 14'h0010, 14'h3FF0, 1'b0, 1'b0);
      tbl[8]  = mk(14'h0005, 14'h0001, 14'h2000, 14'h0100, 14'h0104, 1'b1, 1'b0);
      tbl[9]  = mk(14'h0000, 14'h3FFF, 14'h0000, 14'h0000, 14'h0001, 1'b0, 1'b1);
      tbl[10] = mk(14'h0010, 14'h0010, 14'h0010, 14'h0010, 14'h0010, 1'b1, 1'b0);

      // Reset state, checked with the clock running and RST held.
      @(negedge CLK);
      @(negedge CLK);
      #1;
      chk("rst_out_vld", 32'(OUT_VLD),  32'd0);
      chk("rst_addr",    32'(ADDR_OUT), 32'd0);
      chk("rst_wrap",    32'(WRAP_OUT), 32'd0);
      chk("rst_bor",     32'(BOR_OUT),  32'd0);
      chk("rst_in_rdy",  32'(IN_RDY),   32'd1);
      RST = 1'b0;
      @(negedge CLK);

      // Vector table, one request per cycle with OUT_RDY high.
      foreach (tbl[k]) step(1'b1, tbl[k], 1'b1);
      drain();

      // Throughput: 8 back-to-back requests.
      xfer_cnt = 0; acc_cnt = 0; first_xfer = -1; last_xfer = -1;
      for (int k = 0; k < 8; k++)
         step(1'b1, mk(14'(32'h20 + k), 14'h0001, 14'h0000, 14'h0000,
                       14'(32'h1F + k), 1'b0, 1'b0), 1'b1);
      drain();
      chk("tput_accepts", 32'(acc_cnt),  32'd8);
      chk("tput_outputs", 32'(xfer_cnt), 32'd8);
      chk("tput_contig",  32'(last_xfer - first_xfer), 32'd7);

      // Backpressure: 5 stalled cycles while 3 requests are offered.
      bp[0] = mk(14'h0050, 14'h0010, 14'h0000, 14'h0000, 14'h0040, 1'b0, 1'b0);
      bp[1] = mk(14'h0101, 14'h0002, 14'h0100, 14'h0020, 14'h011F, 1'b1, 1'b0);
      bp[2] = mk(14'h0001, 14'h0002, 14'h0000, 14'h0000, 14'h3FFF, 1'b0, 1'b1);
      acc_cnt = 0; xfer_cnt = 0;
      begin
         int nxt;
         nxt = 0;
         for (int k = 0; k < 5; k++) begin
            step(1'b1, bp[nxt], 1'b0);
            if (last_acc) nxt++;
         end
         chk("bp_accepts_stalled", 32'(acc_cnt), 32'd2);
         chk("bp_no_out_stalled",  32'(xfer_cnt), 32'd0);
         for (int k = 0; k < 10 && nxt < 3; k++) begin
            step(1'b1, bp[nxt], 1'b1);
            if (last_acc) nxt++;
         end
         chk("bp_all_accepted", 32'(nxt), 32'd3);
      end
      drain();
      chk("bp_outputs", 32'(xfer_cnt), 32'd3);

      // Reset mid-flight with both stages holding data.
      step(1'b1, mk(14'h1234, 14'h0034, 14'h0000, 14'h0000, 14'h1200, 1'b0, 1'b0), 1'b0);
      step(1'b1, mk(14'h2000, 14'h0001, 14'h0000, 14'h0000, 14'h1FFF, 1'b0, 1'b0), 1'b0);
      IN_VLD = 1'b0;
      #1;
      chk("pre_rst_out_vld", 32'(OUT_VLD), 32'd1);
      RST = 1'b1;
      #1;
      chk("async_rst_out_vld", 32'(OUT_VLD), 32'd0);
      chk("async_rst_in_rdy",  32'(IN_RDY),  32'd1);
      #1;
      RST = 1'b0;
      sb.delete();
      stall_prev = 1'b0;
      @(negedge CLK);
      xfer_cnt = 0;
      step(1'b1, mk(14'h0777, 14'h0077, 14'h0000, 14'h0000, 14'h0700, 1'b0, 1'b0), 1'b1);
      drain();
      chk("post_rst_outputs", 32'(xfer_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
